// File: rtl/spi_read_reg.sv
// Flash register-read engine: sends opcode, dummy filler and read slots as one SPI
// transaction and returns the captured read bytes as a single wide word.
module spi_read_reg #(
    parameter int               MODULE_ID   = 0,
    parameter int unsigned      DSIZE       = 8,
    parameter logic [7:0]       CMD         = 8'd0,
    parameter int unsigned      SSIZE       = 1,
    parameter logic [DSIZE-1:0] OPCODE      = 8'h9F,
    parameter int unsigned      DUMMY_BYTES = 0,
    parameter int unsigned      RD_BYTES    = 3,
    parameter int unsigned      TIMEOUT     = 4096
) (
    input  logic                         clock,
    input  logic                         rst_n,
    input  logic                         cmd_request,
    input  logic [7:0]                   cmd_cmd,
    output logic                         cmd_busy,
    output logic                         cmd_finish,
    output logic                         spi_request,
    output logic [23:0]                  spi_req_len,
    output logic [23:0]                  spi_req_wr_len,
    output logic                         spi_req_cmd,
    input  logic                         spi_busy,
    input  logic                         spi_clk_en,
    input  logic                         spi_wr_ready,
    output logic                         spi_wr_vld,
    output logic [DSIZE-1:0]             spi_wr_data,
    input  logic                         spi_rd_vld,
    input  logic [DSIZE-1:0]             spi_rd_data,
    output logic [RD_BYTES*DSIZE-1:0]    reg_data,
    output logic                         reg_vld,
    output logic                         reg_err
);

    localparam int unsigned TOTAL   = 1 + DUMMY_BYTES + RD_BYTES;
    localparam int unsigned RW      = RD_BYTES * DSIZE;
    localparam int unsigned REQ_LEN = TOTAL * DSIZE / SSIZE;
    localparam int unsigned TW      = $clog2(TIMEOUT);
    // A misconfigured instance never accepts a command.
    localparam bit PARAMS_OK = (MODULE_ID >= 0) && (SSIZE == 1 || SSIZE == 2 || SSIZE == 4) &&
                               (DUMMY_BYTES <= 4) && (RD_BYTES >= 1) && (RD_BYTES <= 8) &&
                               (TIMEOUT >= 16);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EX_REQ,
        S_REQ_EXEC,
        S_REQ_FSH,
        S_ERR
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [TW-1:0]      r_to_cnt;
    logic [3:0]         r_wr_idx;
    logic [3:0]         r_rd_cnt;
    logic [RW-1:0]      r_shadow;
    logic               r_cmd_busy;
    logic               r_cmd_finish;
    logic               r_spi_request;
    logic               r_wr_vld;
    logic [DSIZE-1:0]   r_wr_data;
    logic [RW-1:0]      r_reg_data;
    logic               r_reg_vld;
    logic               r_reg_err;

    logic               w_start;
    logic               w_timeout;
    logic               w_rd_take;
    logic               w_rd_keep;
    logic               w_wr_acc;
    logic [3:0]         w_rd_cnt_nxt;
    logic [RW-1:0]      w_shadow_nxt;

    assign w_start   = PARAMS_OK && cmd_request && (cmd_cmd == CMD);
    assign w_timeout = (r_to_cnt == TW'(TIMEOUT - 1));
    assign w_wr_acc  = r_wr_vld && spi_wr_ready && spi_clk_en;
    assign w_rd_take = (r_state == S_REQ_EXEC) && spi_rd_vld;
    assign w_rd_keep = w_rd_take && (r_rd_cnt >= 4'(1 + DUMMY_BYTES)) && (r_rd_cnt < 4'(TOTAL));

    // Look-ahead values so a byte arriving on the last busy cycle still counts at finish.
    assign w_rd_cnt_nxt = (w_rd_take && (r_rd_cnt != 4'd15)) ? r_rd_cnt + 4'd1 : r_rd_cnt;
    assign w_shadow_nxt = w_rd_keep ? ((r_shadow << DSIZE) | RW'(spi_rd_data)) : r_shadow;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_start) w_next = S_EX_REQ;
            S_EX_REQ:   if (w_timeout) w_next = S_ERR;
                        else if (spi_busy) w_next = S_REQ_EXEC;
            S_REQ_EXEC: if (w_timeout) w_next = S_ERR;
                        else if (!spi_busy) w_next = S_REQ_FSH;
            S_REQ_FSH:  w_next = S_IDLE;
            S_ERR:      w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_to_cnt      <= '0;
            r_wr_idx      <= '0;
            r_rd_cnt      <= '0;
            r_shadow      <= '0;
            r_cmd_busy    <= 1'b0;
            r_cmd_finish  <= 1'b0;
            r_spi_request <= 1'b0;
            r_wr_vld      <= 1'b0;
            r_wr_data     <= '0;
            r_reg_data    <= '0;
            r_reg_vld     <= 1'b0;
            r_reg_err     <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_cmd_busy    <= (w_next == S_EX_REQ) || (w_next == S_REQ_EXEC);
            r_cmd_finish  <= (w_next == S_REQ_FSH) || (w_next == S_ERR);
            r_spi_request <= (w_next == S_EX_REQ);
            r_reg_vld     <= 1'b0;
            r_reg_err     <= 1'b0;
            r_rd_cnt      <= w_rd_cnt_nxt;
            r_shadow      <= w_shadow_nxt;

            if (r_state == S_IDLE) begin
                r_to_cnt <= '0;
                r_wr_idx <= '0;
                r_rd_cnt <= '0;
            end else if ((r_state == S_EX_REQ) || (r_state == S_REQ_EXEC)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            // Write stream: opcode first, then zero filler for every remaining slot.
            if ((r_state == S_EX_REQ) && (w_next == S_REQ_EXEC)) begin
                r_wr_vld  <= 1'b1;
                r_wr_data <= OPCODE;
            end else if (w_next != S_REQ_EXEC) begin
                r_wr_vld  <= 1'b0;
            end else if (w_wr_acc) begin
                r_wr_idx  <= r_wr_idx + 4'd1;
                r_wr_data <= '0;
                if (r_wr_idx == 4'(TOTAL - 1))
                    r_wr_vld <= 1'b0;
            end

            if ((r_state == S_REQ_EXEC) && (w_next == S_REQ_FSH)) begin
                if (w_rd_cnt_nxt == 4'(TOTAL)) begin
                    r_reg_data <= w_shadow_nxt;
                    r_reg_vld  <= 1'b1;
                end else begin
                    r_reg_err  <= 1'b1;
                end
            end
            if (w_next == S_ERR)
                r_reg_err <= 1'b1;
        end
    end

    assign cmd_busy       = r_cmd_busy;
    assign cmd_finish     = r_cmd_finish;
    assign spi_request    = r_spi_request;
    assign spi_req_len    = 24'(REQ_LEN);
    assign spi_req_wr_len = 24'(REQ_LEN);
    assign spi_req_cmd    = 1'b0;
    assign spi_wr_vld     = r_wr_vld;
    assign spi_wr_data    = r_wr_data;
    assign reg_data       = r_reg_data;
    assign reg_vld        = r_reg_vld;
    assign reg_err        = r_reg_err;

endmodule

// File: tb/tb_spi_read_reg.sv
// Bench for spi_read_reg: two configurations share the dispatcher and SPI-side inputs,
// with an SPI engine model and a byte-level reference of the expected register word.
module tb_spi_read_reg;

    localparam int          TOT_A = 4, DUM_A = 0, NRB_A = 3;
    localparam int          TOT_B = 3, DUM_B = 1, NRB_B = 1;
    localparam logic [7:0]  OPC_A = 8'h9F, OPC_B = 8'h05;
    localparam logic [7:0]  CMD_A = 8'h00, CMD_B = 8'h03;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_request = 1'b0;
    logic [7:0]  cmd_cmd = 8'd0;
    logic        spi_busy = 1'b0, spi_clk_en = 1'b0, spi_wr_ready = 1'b0, spi_rd_vld = 1'b0;
    logic [7:0]  spi_rd_data = 8'd0;

    logic        a_cmd_busy, a_cmd_finish, a_spi_request, a_req_cmd, a_wr_vld, a_reg_vld, a_reg_err;
    logic [23:0] a_len, a_wr_len, a_reg_data;
    logic [7:0]  a_wr_data;
    logic        b_cmd_busy, b_cmd_finish, b_spi_request, b_req_cmd, b_wr_vld, b_reg_vld, b_reg_err;
    logic [23:0] b_len, b_wr_len;
    logic [7:0]  b_wr_data, b_reg_data;

    logic        sel = 1'b0;
    logic        m_busy, m_finish, m_request, m_wr_vld, m_reg_vld, m_reg_err;
    logic [7:0]  m_wr_data;
    logic [63:0] m_reg_data;
    assign m_busy     = sel ? b_cmd_busy    : a_cmd_busy;
    assign m_finish   = sel ? b_cmd_finish  : a_cmd_finish;
    assign m_request  = sel ? b_spi_request : a_spi_request;
    assign m_wr_vld   = sel ? b_wr_vld      : a_wr_vld;
    assign m_wr_data  = sel ? b_wr_data     : a_wr_data;
    assign m_reg_vld  = sel ? b_reg_vld     : a_reg_vld;
    assign m_reg_err  = sel ? b_reg_err     : a_reg_err;
    assign m_reg_data = sel ? {56'd0, b_reg_data} : {40'd0, a_reg_data};

    spi_read_reg #(.MODULE_ID(0), .CMD(CMD_A), .TIMEOUT(64)) u_dut_a (
        .clock(clock), .rst_n(rst_n), .cmd_request(cmd_request), .cmd_cmd(cmd_cmd),
        .cmd_busy(a_cmd_busy), .cmd_finish(a_cmd_finish), .spi_request(a_spi_request),
        .spi_req_len(a_len), .spi_req_wr_len(a_wr_len), .spi_req_cmd(a_req_cmd),
        .spi_busy(spi_busy), .spi_clk_en(spi_clk_en), .spi_wr_ready(spi_wr_ready),
        .spi_wr_vld(a_wr_vld), .spi_wr_data(a_wr_data), .spi_rd_vld(spi_rd_vld),
        .spi_rd_data(spi_rd_data), .reg_data(a_reg_data), .reg_vld(a_reg_vld), .reg_err(a_reg_err)
    );

    spi_read_reg #(.MODULE_ID(1), .CMD(CMD_B), .SSIZE(4), .OPCODE(OPC_B), .DUMMY_BYTES(1),
                   .RD_BYTES(1)) u_dut_b (
        .clock(clock), .rst_n(rst_n), .cmd_request(cmd_request), .cmd_cmd(cmd_cmd),
        .cmd_busy(b_cmd_busy), .cmd_finish(b_cmd_finish), .spi_request(b_spi_request),
        .spi_req_len(b_len), .spi_req_wr_len(b_wr_len), .spi_req_cmd(b_req_cmd),
        .spi_busy(spi_busy), .spi_clk_en(spi_clk_en), .spi_wr_ready(spi_wr_ready),
        .spi_wr_vld(b_wr_vld), .spi_wr_data(b_wr_data), .spi_rd_vld(spi_rd_vld),
        .spi_rd_data(spi_rd_data), .reg_data(b_reg_data), .reg_vld(b_reg_vld), .reg_err(b_reg_err)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad = 0;
    logic [23:0] mdl_a = 24'd0;
    logic [7:0]  mdl_b = 8'd0;
    logic [7:0]  rd_src [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_reg(input logic s);
        return s ? 64'(mdl_b) : 64'(mdl_a);
    endfunction

    // One full command on instance s, returning n_rd read bytes from rd_src.
    task automatic run_txn(input logic s, input int n_rd);
        int          tot, dum, nrb, nw, n;
        logic [7:0]  opc;
        logic [7:0]  wr_got [16];
        logic [63:0] expw;
        bit          good;
        sel = s;
        tot = s ? TOT_B : TOT_A;
        dum = s ? DUM_B : DUM_A;
        nrb = s ? NRB_B : NRB_A;
        opc = s ? OPC_B : OPC_A;
        @(negedge clock);
        cmd_request = 1'b1;
        cmd_cmd = s ? CMD_B : CMD_A;
        @(negedge clock);
        cmd_request = 1'b0;
        check("spi_request_up", 64'(m_request), 64'd1);
        check("cmd_busy_up", 64'(m_busy), 64'd1);
        check("other_idle", 64'(s ? a_cmd_busy : b_cmd_busy), 64'd0);
        spi_busy = 1'b1;
        @(negedge clock);
        check("spi_request_drop", 64'(m_request), 64'd0);
        nw = 0;
        n = 0;
        while (nw < tot && n < 40) begin
            spi_wr_ready = ($urandom_range(3) != 0);
            spi_clk_en   = ($urandom_range(3) != 0);
            if (m_wr_vld && spi_wr_ready && spi_clk_en) begin
                wr_got[nw] = m_wr_data;
                nw++;
            end
            @(negedge clock);
            n++;
        end
        spi_wr_ready = 1'b0;
        spi_clk_en = 1'b0;
        check("wr_count", 64'(nw), 64'(tot));
        check("wr_vld_end", 64'(m_wr_vld), 64'd0);
        for (int i = 0; i < nw; i++)
            check("wr_byte", 64'(wr_got[i]), (i == 0) ? 64'(opc) : 64'd0);
        for (int i = 0; i < n_rd; i++) begin
            spi_rd_vld = 1'b1;
            spi_rd_data = rd_src[i];
            @(negedge clock);
            spi_rd_vld = 1'b0;
            if ($urandom_range(1) == 1) @(negedge clock);
        end
        spi_busy = 1'b0;
        @(negedge clock);
        good = (n_rd == tot);
        if (good) begin
            expw = 64'd0;
            for (int k = 0; k < nrb; k++)
                expw = expw * 256 + 64'(rd_src[1 + dum + k]);
            if (s) mdl_b = expw[7:0];
            else   mdl_a = expw[23:0];
        end
        check("finish_pulse", 64'(m_finish), 64'd1);
        check("busy_at_finish", 64'(m_busy), 64'd0);
        check("reg_vld", 64'(m_reg_vld), 64'(good));
        check("reg_err", 64'(m_reg_err), 64'(!good));
        check("reg_data", m_reg_data, model_reg(s));
        @(negedge clock);
        check("finish_one_cycle", 64'(m_finish), 64'd0);
        check("vld_err_clear", 64'({m_reg_vld, m_reg_err}), 64'd0);
        check("reg_data_hold", m_reg_data, model_reg(s));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        logic s;
        repeat (3) @(negedge clock);
        check("rst_busy", 64'({a_cmd_busy, b_cmd_busy}), 64'd0);
        check("rst_finish", 64'({a_cmd_finish, b_cmd_finish}), 64'd0);
        check("rst_request", 64'({a_spi_request, b_spi_request}), 64'd0);
        check("rst_wr_vld", 64'({a_wr_vld, b_wr_vld}), 64'd0);
        check("rst_reg_data_a", 64'(a_reg_data), 64'd0);
        check("rst_pulses", 64'({a_reg_vld, a_reg_err, b_reg_vld, b_reg_err}), 64'd0);
        check("len_a", 64'(a_len), 64'd32);
        check("wr_len_a", 64'(a_wr_len), 64'd32);
        check("len_b", 64'(b_len), 64'd6);
        check("wr_len_b", 64'(b_wr_len), 64'd6);
        check("req_cmd", 64'({a_req_cmd, b_req_cmd}), 64'd0);
        rst_n = 1'b1;

        // RDID on the default configuration.
        rd_src[0] = 8'h00; rd_src[1] = 8'hEF; rd_src[2] = 8'h40; rd_src[3] = 8'h18;
        run_txn(1'b0, 4);
        check("rdid_value", 64'(a_reg_data), 64'hEF4018);

        // RDSR with one dummy byte on quad lanes.
        rd_src[0] = 8'h00; rd_src[1] = 8'h00; rd_src[2] = 8'h5A;
        run_txn(1'b1, 3);
        check("rdsr_value", 64'(b_reg_data), 64'h5A);

        // Unknown command code starts neither instance.
        @(negedge clock);
        cmd_request = 1'b1;
        cmd_cmd = 8'h07;
        @(negedge clock);
        cmd_request = 1'b0;
        repeat (3) begin
            check("badcmd_request", 64'({a_spi_request, b_spi_request}), 64'd0);
            check("badcmd_busy", 64'({a_cmd_busy, b_cmd_busy}), 64'd0);
            @(negedge clock);
        end

        // Short and long read streams must both be rejected.
        rd_src[1] = 8'h11; rd_src[2] = 8'h22; rd_src[3] = 8'h33; rd_src[4] = 8'h44;
        run_txn(1'b0, 3);
        run_txn(1'b0, 5);

        // Timeout with spi_busy never asserted; a mid-command request is ignored.
        sel = 1'b0;
        @(negedge clock);
        cmd_request = 1'b1;
        cmd_cmd = CMD_A;
        @(negedge clock);
        cmd_request = 1'b0;
        n = 0;
        while (!a_cmd_finish && n < 200) begin
            cmd_request = (n == 10);
            @(negedge clock);
            n++;
            if (n == 30) check("to_request_held", 64'(a_spi_request), 64'd1);
        end
        cmd_request = 1'b0;
        check("to_cycles", 64'(n), 64'd64);
        check("to_err", 64'(a_reg_err), 64'd1);
        check("to_no_vld", 64'(a_reg_vld), 64'd0);
        check("to_request_drop", 64'(a_spi_request), 64'd0);
        check("to_busy_drop", 64'(a_cmd_busy), 64'd0);
        check("to_reg_held", 64'(a_reg_data), 64'(mdl_a));
        @(negedge clock);
        check("to_idle", 64'({a_cmd_finish, a_reg_err, a_cmd_busy}), 64'd0);

        // Randomised transactions on both instances.
        for (int it = 0; it < 24; it++) begin
            s = 1'($urandom_range(1));
            for (int i = 0; i < 16; i++) rd_src[i] = 8'($urandom);
            r = $urandom_range(7);
            n = s ? TOT_B : TOT_A;
            if (r == 0) n = n - 1;
            else if (r == 1) n = n + 1;
            else if (r == 2) n = n + 2;
            run_txn(s, n);
        end

        // Asynchronous reset in the middle of a transfer, then a clean command.
        sel = 1'b0;
        @(negedge clock);
        cmd_request = 1'b1;
        cmd_cmd = CMD_A;
        @(negedge clock);
        cmd_request = 1'b0;
        spi_busy = 1'b1;
        @(negedge clock);
        check("pre_rst_wr_vld", 64'(a_wr_vld), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        mdl_a = 24'd0;
        mdl_b = 8'd0;
        check("async_rst_ctrl", 64'({a_cmd_busy, a_cmd_finish, a_spi_request, a_wr_vld}), 64'd0);
        check("async_rst_wr_data", 64'(a_wr_data), 64'd0);
        check("async_rst_pulses", 64'({a_reg_vld, a_reg_err}), 64'd0);
        check("async_rst_reg_a", 64'(a_reg_data), 64'(mdl_a));
        check("async_rst_reg_b", 64'(b_reg_data), 64'(mdl_b));
        @(negedge clock);
        spi_busy = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        rd_src[0] = 8'h00; rd_src[1] = 8'hC2; rd_src[2] = 8'h20; rd_src[3] = 8'h17;
        run_txn(1'b0, 4);
        check("post_rst_value", 64'(a_reg_data), 64'hC22017);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
